// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared access-size codes, responder state encoding and a
//                helper that turns an access size into its byte count.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_responder_pkg;

    localparam logic [1:0] DSIZE_BYTE    = 2'd0;
    localparam logic [1:0] DSIZE_HALF    = 2'd1;
    localparam logic [1:0] DSIZE_ILLEGAL = 2'd2;
    localparam logic [1:0] DSIZE_WORD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Number of bytes touched by an access; the illegal code reports 4 so the
    // range check stays conservative (it is rejected separately anyway).
    function automatic logic [2:0] dsizeBytes(input logic [1:0] dsize);
        case (dsize)
            DSIZE_BYTE: return 3'd1;
            DSIZE_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational big-endian lane steering for the data memory.
//                Store path: address low bits + size -> byte enables and
//                shifted write data. Load path: address low bits + size +
//                extension mode -> right-justified, extended load result.
//  Ports       : i_addrLow      byte offset within the word
//                i_dsize        access size code
//                i_wdata        right-justified store data
//                i_loadExt      1 = sign-extend, 0 = zero-extend
//                i_word         word read from the array
//                o_byteEn       byte enables, bit j covers word bits [8j+7:8j]
//                o_wdataShifted store data moved onto its lanes
//                o_rdata        extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_addrLow,
    input  logic [1:0]  i_dsize,
    input  logic [31:0] i_wdata,
    input  logic        i_loadExt,
    input  logic [31:0] i_word,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wdataShifted,
    output logic [31:0] o_rdata
);

    // Big-endian: byte offset 0 lives in the most significant lane (3).
    logic [1:0]  w_lane;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_lane  = 2'd3 - i_addrLow;
    assign w_shift = {w_lane, 3'b000};

    always_comb begin
        o_byteEn       = 4'b0000;
        o_wdataShifted = 32'h0;
        o_rdata        = 32'h0;
        w_byte         = i_word[w_shift +: 8];
        // Halves sit at offset 0 (upper) or offset 2 (lower).
        w_half         = i_addrLow[1] ? i_word[15:0] : i_word[31:16];
        case (i_dsize)
            DSIZE_BYTE: begin
                o_byteEn       = 4'b0001 << w_lane;
                o_wdataShifted = {24'h0, i_wdata[7:0]} << w_shift;
                o_rdata        = {{24{i_loadExt & w_byte[7]}}, w_byte};
            end
            DSIZE_HALF: begin
                o_byteEn       = i_addrLow[1] ? 4'b0011 : 4'b1100;
                o_wdataShifted = i_addrLow[1] ? {16'h0, i_wdata[15:0]}
                                              : {i_wdata[15:0], 16'h0};
                o_rdata        = {{16{i_loadExt & w_half[15]}}, w_half};
            end
            DSIZE_WORD: begin
                o_byteEn       = 4'b1111;
                o_wdataShifted = i_wdata;
                o_rdata        = i_word;
            end
            default: begin
                o_byteEn       = 4'b0000;
                o_wdataShifted = 32'h0;
                o_rdata        = 32'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data-memory responder with configurable
//                wait states. Accepts a load/store through req_valid/ready,
//                waits LATENCY cycles, accesses a big-endian word array for
//                one cycle, then holds the response until resp_ready.
//  Parameters  : SIZE     memory size in bytes (multiple of 4)
//                LATENCY  wait cycles between acceptance and array access
//  Ports       : clk, reset (synchronous, active high)
//                req_valid/req_ready/req_wr/req_addr/req_wdata/req_dsize/
//                req_loadext   request channel
//                resp_valid/resp_ready/resp_rdata/resp_err  response channel
//                busy          high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int SIZE    = 16384,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_dsize,
    input  logic        req_loadext,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int c_ADDR_W = $clog2(SIZE);
    localparam int c_DEPTH  = SIZE / 4;
    localparam int c_CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT =
        c_CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_t               r_state;
    state_t               w_nextState;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_wr;
    logic [c_ADDR_W-1:0]  r_addr;
    logic [31:0]          r_wdata;
    logic [1:0]           r_dsize;
    logic                 r_loadExt;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic [31:0]          r_mem [c_DEPTH];

    logic                 w_reqErr;
    logic [c_ADDR_W-3:0]  w_wordIdx;
    logic [31:0]          w_word;
    logic [3:0]           w_byteEn;
    logic [31:0]          w_wdataShifted;
    logic [31:0]          w_loadData;

    // Legality is judged on the live request; the range check is done in 33
    // bits so addresses near 2^32 cannot wrap into the legal window.
    always_comb begin
        w_reqErr = 1'b0;
        if (req_dsize == DSIZE_ILLEGAL)
            w_reqErr = 1'b1;
        if ((req_dsize == DSIZE_HALF) && req_addr[0])
            w_reqErr = 1'b1;
        if ((req_dsize == DSIZE_WORD) && (req_addr[1:0] != 2'b00))
            w_reqErr = 1'b1;
        if ({1'b0, req_addr} > (33'(SIZE) - 33'(dsizeBytes(req_dsize))))
            w_reqErr = 1'b1;
    end

    assign w_wordIdx = r_addr[c_ADDR_W-1:2];
    assign w_word    = r_mem[w_wordIdx];

    dmem_lane_align u_laneAlign (
        .i_addrLow      (r_addr[1:0]),
        .i_dsize        (r_dsize),
        .i_wdata        (r_wdata),
        .i_loadExt      (r_loadExt),
        .i_word         (w_word),
        .o_byteEn       (w_byteEn),
        .o_wdataShifted (w_wdataShifted),
        .o_rdata        (w_loadData)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid)
                    w_nextState = w_reqErr ? ST_RESP
                                           : ((LATENCY > 0) ? ST_WAIT : ST_ACCESS);
            end
            ST_WAIT: begin
                if (r_cnt == '0)
                    w_nextState = ST_ACCESS;
            end
            ST_ACCESS: w_nextState = ST_RESP;
            ST_RESP: begin
                if (resp_ready)
                    w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'h0;
            r_dsize   <= DSIZE_BYTE;
            r_loadExt <= 1'b0;
            r_rdata   <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wr      <= req_wr;
                        r_addr    <= req_addr[c_ADDR_W-1:0];
                        r_wdata   <= req_wdata;
                        r_dsize   <= req_dsize;
                        r_loadExt <= req_loadext;
                        r_err     <= w_reqErr;
                        r_rdata   <= 32'h0;
                        r_cnt     <= c_CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - 1'b1;
                end
                ST_ACCESS: begin
                    r_rdata <= r_wr ? 32'h0 : w_loadData;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; a store commits only on the ACCESS edge, so a reset
    // arriving earlier drops it and one arriving later cannot undo it.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_ACCESS) && r_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteEn[i])
                    r_mem[w_wordIdx][8*i +: 8] <= w_wdataShifted[8*i +: 8];
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench. dutA is built with LATENCY=2,
//                dutB with LATENCY=0; both share request fields, reset and
//                resp_ready but have separate req_valid lines.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int SIZE = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        valA, valB;
    logic        req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_dsize;
    logic        req_loadext;
    logic        resp_ready;
    logic        readyA, respValidA, errA, busyA;
    logic        readyB, respValidB, errB, busyB;
    logic [31:0] rdataA, rdataB;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_responder #(.SIZE(SIZE), .LATENCY(2)) dutA (
        .clk(clk), .reset(reset), .req_valid(valA), .req_ready(readyA),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_dsize(req_dsize), .req_loadext(req_loadext),
        .resp_valid(respValidA), .resp_ready(resp_ready),
        .resp_rdata(rdataA), .resp_err(errA), .busy(busyA)
    );

    dmem_responder #(.SIZE(SIZE), .LATENCY(0)) dutB (
        .clk(clk), .reset(reset), .req_valid(valB), .req_ready(readyB),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_dsize(req_dsize), .req_loadext(req_loadext),
        .resp_valid(respValidB), .resp_ready(resp_ready),
        .resp_rdata(rdataB), .resp_err(errB), .busy(busyB)
    );

    // Drives one request, scrambles the fields right after acceptance, and
    // reports the cycle (counted from the acceptance edge) in which
    // resp_valid was first seen. resp_ready must be high.
    task automatic issue(input bit sel, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] dsize,
                         input bit ext, output int lat,
                         output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_wr = wr; req_addr = addr; req_wdata = wdata;
        req_dsize = dsize; req_loadext = ext;
        if (sel) valB = 1'b1; else valA = 1'b1;
        @(posedge clk); #1;
        valA = 1'b0; valB = 1'b0;
        req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata;
        req_dsize = ~dsize; req_loadext = ~ext;
        lat = 1;
        while (((sel ? respValidB : respValidA) !== 1'b1) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = sel ? rdataB : rdataA;
        err   = sel ? errB : errA;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valA = 1'b0; valB = 1'b0; resp_ready = 1'b1;
        req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_dsize = DSIZE_WORD; req_loadext = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({readyA, respValidA, errA, busyA, rdataA} !== {4'b1000, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_A ready/valid/err/busy/rdata got %b%b%b%b %h want 1000 00000000",
                     readyA, respValidA, errA, busyA, rdataA);
        end
        vectors++;
        if ({readyB, respValidB, errB, busyB, rdataB} !== {4'b1000, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_B ready/valid/err/busy/rdata got %b%b%b%b %h want 1000 00000000",
                     readyB, respValidB, errB, busyB, rdataB);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_word_store_load();
        int lat; logic [31:0] rd; logic er;
        issue(0, 1, 32'h100, 32'h11223344, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({lat, er, rd} !== {32'd4, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL store_word lat/err/rdata got %0d %b %h want 4 0 00000000", lat, er, rd);
        end
        issue(0, 0, 32'h100, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({lat, er, rd} !== {32'd4, 1'b0, 32'h11223344}) begin
            miscompares++;
            $display("FAIL load_word lat/err/rdata got %0d %b %h want 4 0 11223344", lat, er, rd);
        end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er;
        issue(0, 0, 32'h101, 32'h0, DSIZE_BYTE, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'h00000022) begin
            miscompares++;
            $display("FAIL load_byte_101_zext rdata got %h want 00000022", rd);
        end
        issue(0, 0, 32'h102, 32'h0, DSIZE_HALF, 1, lat, rd, er);
        vectors++;
        if (rd !== 32'h00003344) begin
            miscompares++;
            $display("FAIL load_half_102_sext rdata got %h want 00003344", rd);
        end
        issue(0, 0, 32'h100, 32'h0, DSIZE_HALF, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'h00001122) begin
            miscompares++;
            $display("FAIL load_half_100 rdata got %h want 00001122", rd);
        end
        issue(0, 1, 32'h103, 32'hFFFFFF80, DSIZE_BYTE, 0, lat, rd, er);
        issue(0, 0, 32'h103, 32'h0, DSIZE_BYTE, 1, lat, rd, er);
        vectors++;
        if (rd !== 32'hFFFFFF80) begin
            miscompares++;
            $display("FAIL load_byte_103_sext rdata got %h want ffffff80", rd);
        end
        issue(0, 0, 32'h103, 32'h0, DSIZE_BYTE, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'h00000080) begin
            miscompares++;
            $display("FAIL load_byte_103_zext rdata got %h want 00000080", rd);
        end
        issue(0, 0, 32'h100, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'h11223380) begin
            miscompares++;
            $display("FAIL load_word_after_byte rdata got %h want 11223380", rd);
        end
        issue(0, 1, 32'h104, 32'h0000ABCD, DSIZE_HALF, 0, lat, rd, er);
        issue(0, 1, 32'h106, 32'h00008001, DSIZE_HALF, 0, lat, rd, er);
        issue(0, 0, 32'h104, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'hABCD8001) begin
            miscompares++;
            $display("FAIL two_half_stores word got %h want abcd8001", rd);
        end
        issue(0, 0, 32'h106, 32'h0, DSIZE_HALF, 1, lat, rd, er);
        vectors++;
        if (rd !== 32'hFFFF8001) begin
            miscompares++;
            $display("FAIL load_half_106_sext rdata got %h want ffff8001", rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        issue(0, 0, 32'h101, 32'h0, DSIZE_HALF, 0, lat, rd, er);
        vectors++;
        if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL err_half_misaligned lat/err/rdata got %0d %b %h want 1 1 00000000", lat, er, rd);
        end
        issue(0, 0, 32'h100, 32'h0, DSIZE_ILLEGAL, 0, lat, rd, er);
        vectors++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL err_dsize2 err/rdata got %b %h want 1 00000000", er, rd);
        end
        issue(0, 1, SIZE - 4, 32'hA5A5A5A5, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({lat, er} !== {32'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL store_word_top lat/err got %0d %b want 4 0", lat, er);
        end
        issue(0, 1, SIZE - 2, 32'h00000000, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({lat, er} !== {32'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL err_word_size_minus_2 lat/err got %0d %b want 1 1", lat, er);
        end
        issue(0, 0, SIZE - 4, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin
            miscompares++;
            $display("FAIL word_top_unchanged err/rdata got %b %h want 0 a5a5a5a5", er, rd);
        end
        issue(0, 1, SIZE - 1, 32'h0000005A, DSIZE_BYTE, 0, lat, rd, er);
        vectors++;
        if (er !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_last_legal err got %b want 0", er);
        end
        issue(0, 0, SIZE, 32'h0, DSIZE_BYTE, 0, lat, rd, er);
        vectors++;
        if ({lat, er} !== {32'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL err_byte_at_size lat/err got %0d %b want 1 1", lat, er);
        end
        issue(0, 0, 32'hFFFFFFFC, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (er !== 1'b1) begin
            miscompares++;
            $display("FAIL err_word_high_addr err got %b want 1", er);
        end
        issue(0, 0, SIZE - 4, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'hA5A5A55A) begin
            miscompares++;
            $display("FAIL word_top_after_byte rdata got %h want a5a5a55a", rd);
        end
    endtask

    task automatic test_backpressure();
        int wait_cnt;
        resp_ready = 1'b0;
        @(negedge clk);
        req_wr = 1'b0; req_addr = 32'h100; req_dsize = DSIZE_WORD; req_loadext = 1'b0;
        valA = 1'b1;
        @(posedge clk); #1;
        valA = 1'b0; req_addr = 32'h0;
        wait_cnt = 0;
        while (respValidA !== 1'b1 && wait_cnt < 40) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({respValidA, readyA, busyA, rdataA} !== {3'b101, 32'h11223380}) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d] valid/ready/busy/rdata got %b%b%b %h want 101 11223380",
                         i, respValidA, readyA, busyA, rdataA);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({respValidA, readyA, busyA, rdataA} !== {3'b010, 32'h0}) begin
            miscompares++;
            $display("FAIL backpressure_release valid/ready/busy/rdata got %b%b%b %h want 010 00000000",
                     respValidA, readyA, busyA, rdataA);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; int wait_cnt; logic [31:0] rd; logic er;
        issue(0, 1, 32'h200, 32'hCAFEF00D, DSIZE_WORD, 0, lat, rd, er);
        // Store accepted, then reset while it is still waiting.
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h200; req_wdata = 32'hDEADBEEF; req_dsize = DSIZE_WORD;
        valA = 1'b1;
        @(posedge clk); #1;
        valA = 1'b0;
        vectors++;
        if (busyA !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_busy busy got %b want 1", busyA);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({readyA, respValidA, errA, busyA, rdataA} !== {4'b1000, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_in_wait ready/valid/err/busy/rdata got %b%b%b%b %h want 1000 00000000",
                     readyA, respValidA, errA, busyA, rdataA);
        end
        @(negedge clk); reset = 1'b0;
        issue(0, 0, 32'h200, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL reset_in_wait_mem rdata got %h want cafef00d", rd);
        end
        // Reset together with a valid request: the request must be ignored.
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h200; req_wdata = 32'h77777777; req_dsize = DSIZE_WORD;
        valA = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        valA = 1'b0;
        @(negedge clk); reset = 1'b0;
        vectors++;
        if (busyA !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_with_valid busy got %b want 0", busyA);
        end
        // Store parked in RESP, then reset: data stays committed.
        resp_ready = 1'b0;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h204; req_wdata = 32'h12345678; req_dsize = DSIZE_WORD;
        valA = 1'b1;
        @(posedge clk); #1;
        valA = 1'b0;
        wait_cnt = 0;
        while (respValidA !== 1'b1 && wait_cnt < 40) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({respValidA, readyA} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_in_resp valid/ready got %b%b want 01", respValidA, readyA);
        end
        @(negedge clk); reset = 1'b0; resp_ready = 1'b1;
        issue(0, 0, 32'h204, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'h12345678) begin
            miscompares++;
            $display("FAIL reset_in_resp_mem rdata got %h want 12345678", rd);
        end
        issue(0, 0, 32'h200, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if (rd !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL reset_with_valid_mem rdata got %h want cafef00d", rd);
        end
    endtask

    task automatic test_latency0();
        int lat; logic [31:0] rd; logic er;
        issue(1, 1, 32'h10, 32'h0BADF00D, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({lat, er} !== {32'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL lat0_store lat/err got %0d %b want 2 0", lat, er);
        end
        issue(1, 0, 32'h12, 32'h0, DSIZE_HALF, 1, lat, rd, er);
        vectors++;
        if ({lat, er, rd} !== {32'd2, 1'b0, 32'hFFFFF00D}) begin
            miscompares++;
            $display("FAIL lat0_load_half lat/err/rdata got %0d %b %h want 2 0 fffff00d", lat, er, rd);
        end
        issue(1, 0, 32'h13, 32'h0, DSIZE_WORD, 0, lat, rd, er);
        vectors++;
        if ({lat, er} !== {32'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL lat0_err lat/err got %0d %b want 1 1", lat, er);
        end
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int responses = 0;
        int iter = 0;
        int lat; logic [31:0] rd; logic er;
        @(negedge clk);
        valB = 1'b1;
        req_wr = 1'b1; req_dsize = DSIZE_WORD; req_loadext = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hB0B00000;
        accepted = 1;
        iter = 1;
        while (iter < 100) begin
            @(negedge clk);
            iter++;
            if (respValidB === 1'b1) responses++;
            if (readyB === 1'b1) begin
                if (accepted == 4) break;
                req_addr  = 32'h40 + 32'(4 * accepted);
                req_wdata = 32'hB0B00000 + 32'(accepted);
                accepted++;
            end
        end
        valB = 1'b0;
        vectors++;
        if (responses !== 4) begin
            miscompares++;
            $display("FAIL b2b_responses got %0d want 4", responses);
        end
        vectors++;
        if (iter !== 13) begin
            miscompares++;
            $display("FAIL b2b_cycles got %0d want 13", iter);
        end
        for (int k = 0; k < 4; k++) begin
            issue(1, 0, 32'h40 + 32'(4 * k), 32'h0, DSIZE_WORD, 0, lat, rd, er);
            vectors++;
            if (rd !== 32'hB0B00000 + 32'(k)) begin
                miscompares++;
                $display("FAIL b2b_readback[%0d] rdata got %h want %h", k, rd, 32'hB0B00000 + 32'(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_latency0();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
